// File: rtl/periph_ctrl_demux_if.sv
// periph_ctrl_demux_if: upstream request/response bus plus per-target control bus
interface periph_ctrl_demux_if #(
  parameter int unsigned NumTargets = 4,
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned DataWidth  = 32
);
  logic                                 req_valid;
  logic                                 req_ready;
  logic [AddrWidth-1:0]                 req_addr;
  logic                                 req_we;
  logic [DataWidth-1:0]                 req_wdata;
  logic [DataWidth/8-1:0]               req_be;
  logic                                 rsp_valid;
  logic                                 rsp_ready;
  logic [DataWidth-1:0]                 rsp_rdata;
  logic                                 rsp_err;
  logic [NumTargets-1:0]                tgt_req_valid;
  logic [NumTargets-1:0]                tgt_req_ready;
  logic [AddrWidth-1:0]                 tgt_req_addr;
  logic                                 tgt_req_we;
  logic [DataWidth-1:0]                 tgt_req_wdata;
  logic [DataWidth/8-1:0]               tgt_req_be;
  logic [NumTargets-1:0]                tgt_rsp_valid;
  logic [NumTargets-1:0][DataWidth-1:0] tgt_rsp_rdata;
  logic [NumTargets-1:0]                tgt_rsp_err;
  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, req_be, rsp_ready,
           tgt_req_ready, tgt_rsp_valid, tgt_rsp_rdata, tgt_rsp_err,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           tgt_req_valid, tgt_req_addr, tgt_req_we, tgt_req_wdata, tgt_req_be
  );
  modport master (
    output req_valid, req_addr, req_we, req_wdata, req_be, rsp_ready,
           tgt_req_ready, tgt_rsp_valid, tgt_rsp_rdata, tgt_rsp_err,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           tgt_req_valid, tgt_req_addr, tgt_req_we, tgt_req_wdata, tgt_req_be
  );
endinterface

// File: rtl/periph_ctrl_demux.sv
// periph_ctrl_demux: address-decoded request demux with in-order response FIFO
module periph_ctrl_demux #(
  parameter int unsigned          NumTargets     = 4,
  parameter int unsigned          AddrWidth      = 32,
  parameter int unsigned          DataWidth      = 32,
  parameter logic [AddrWidth-1:0] BaseAddr       = 32'h4000_0000,
  parameter int unsigned          RegionSizeLog2 = 12,
  parameter int unsigned          MaxOutstanding = 4
) (
  input logic               clk_i,
  input logic               rst_ni,
  periph_ctrl_demux_if.slave bus
);
  localparam int unsigned TW = $clog2(NumTargets + 1);
  localparam int unsigned CW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PW = MaxOutstanding > 1 ? $clog2(MaxOutstanding) : 1;
  localparam logic [TW-1:0] Err = TW'(NumTargets);

  logic [AddrWidth-1:0]  off, idx_full;
  logic                  dec_err, grant, hs, pop, push, tgt_hit, tgt_err;
  logic [TW-1:0]         tgt, cur_q;
  logic [NumTargets-1:0] sel, cur_oh;
  logic [CW-1:0]         cnt_q, occ_q;
  logic [PW-1:0]         wptr_q, rptr_q;
  logic [DataWidth-1:0]  tgt_rdata;
  logic [DataWidth:0]    push_data;
  logic [DataWidth:0]    mem_q [MaxOutstanding];

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(MaxOutstanding - 1) ? '0 : p + PW'(1);
  endfunction

  assign off      = bus.req_addr - BaseAddr;
  assign idx_full = off >> RegionSizeLog2;
  assign dec_err  = (bus.req_addr < BaseAddr) || (idx_full >= AddrWidth'(NumTargets));
  assign tgt      = dec_err ? Err : idx_full[TW-1:0];
  // A new target may only be addressed once every earlier response has drained
  assign grant    = rst_ni && (cnt_q < CW'(MaxOutstanding)) && (cnt_q == '0 || cur_q == tgt);

  // One-hot decode of the request target and response mux from the current target
  always_comb begin
    sel = '0;
    cur_oh = '0;
    tgt_rdata = '0;
    tgt_err = 1'b0;
    for (int k = 0; k < NumTargets; k++) begin
      sel[k] = !dec_err && tgt == TW'(k);
      cur_oh[k] = cur_q == TW'(k);
      tgt_rdata |= (cur_q == TW'(k)) ? bus.tgt_rsp_rdata[k] : '0;
      tgt_err |= (cur_q == TW'(k)) && bus.tgt_rsp_err[k];
    end
  end

  assign bus.tgt_req_valid = sel & {NumTargets{bus.req_valid && grant}};
  assign bus.req_ready     = grant && (dec_err || |(sel & bus.tgt_req_ready));
  assign bus.tgt_req_addr  = bus.req_addr;
  assign bus.tgt_req_we    = bus.req_we;
  assign bus.tgt_req_wdata = bus.req_wdata;
  assign bus.tgt_req_be    = bus.req_be;

  assign hs        = bus.req_valid && bus.req_ready;
  assign tgt_hit   = |(cur_oh & bus.tgt_rsp_valid) && cnt_q != occ_q;
  assign push      = tgt_hit || (hs && dec_err);
  assign push_data = tgt_hit ? {tgt_rdata, tgt_err} : {{DataWidth{1'b0}}, 1'b1};

  assign bus.rsp_valid = occ_q != '0;
  assign pop           = bus.rsp_valid && bus.rsp_ready;
  assign bus.rsp_rdata = bus.rsp_valid ? mem_q[rptr_q][DataWidth:1] : '0;
  assign bus.rsp_err   = bus.rsp_valid && mem_q[rptr_q][0];

  // Outstanding counter, FIFO pointers/occupancy and current-target register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      occ_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cur_q  <= Err;
    end else begin
      cnt_q  <= cnt_q + CW'(hs) - CW'(pop);
      occ_q  <= occ_q + CW'(push) - CW'(pop);
      wptr_q <= push ? nxt(wptr_q) : wptr_q;
      rptr_q <= pop ? nxt(rptr_q) : rptr_q;
      cur_q  <= hs ? tgt : cur_q;
    end
  end

  // Response storage; contents are only observed through a valid head entry
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= push_data;
  end

  // Overflow is a design error; unexpected target responses are dropped and reported
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(push && occ_q == CW'(MaxOutstanding))) else $error("response fifo overflow");
      assert (!(|bus.tgt_rsp_valid) || tgt_hit) else $warning("unexpected target response ignored");
    end
  end
endmodule

// File: tb/tb_periph_ctrl_demux.sv
// tb_periph_ctrl_demux: directed and randomized checks against a queue-based model
module tb_periph_ctrl_demux;
  localparam logic [31:0] Base = 32'h4000_0000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   outst = 0;
  int   last = 4;
  int   await_q[$];
  logic [32:0] rq[$];

  always #5 clk = ~clk;

  periph_ctrl_demux_if bus ();
  periph_ctrl_demux dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int dec(logic [31:0] a);
    logic [31:0] o;
    o = a - Base;
    if (a < Base || (o >> 12) >= 4) return 4;
    return int'(o >> 12);
  endfunction

  // Model: every cycle compare outputs, then advance by the handshakes of the coming edge
  always @(negedge clk) begin
    int t;
    logic g, er;
    logic [3:0] ev;
    t = dec(bus.req_addr);
    g = rst_n && outst < 4 && (outst == 0 || last == t);
    er = g && ((t == 4) || bus.tgt_req_ready[t % 4]);
    ev = (bus.req_valid && g && t < 4) ? 4'(1 << t) : 4'b0;
    chk("req_ready", 64'(bus.req_ready), 64'(er));
    chk("tgt_req_valid", 64'(bus.tgt_req_valid), 64'(ev));
    chk("tgt_req_addr", 64'(bus.tgt_req_addr), 64'(bus.req_addr));
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(rq.size() > 0));
    chk("rsp_rdata", 64'(bus.rsp_rdata), rq.size() > 0 ? 64'(rq[0][32:1]) : 64'h0);
    chk("rsp_err", 64'(bus.rsp_err), rq.size() > 0 ? 64'(rq[0][0]) : 64'h0);
    if (!rst_n) begin
      outst = 0;
      last = 4;
      await_q.delete();
      rq.delete();
    end else begin
      if (bus.rsp_ready && rq.size() > 0) begin
        void'(rq.pop_front());
        outst--;
      end
      for (int k = 0; k < 4; k++)
        if (bus.tgt_rsp_valid[k] && await_q.size() > 0 && (await_q[0] & 7) == k) begin
          rq.push_back({bus.tgt_rsp_rdata[k], bus.tgt_rsp_err[k]});
          void'(await_q.pop_front());
        end
      if (bus.req_valid && er) begin
        outst++;
        last = t;
        if (t == 4) rq.push_back({32'h0, 1'b1});
        else await_q.push_back(t | (bus.req_we ? 16 : 0));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(logic [31:0] a, logic we);
    bus.req_valid = 1'b1;
    bus.req_addr = a;
    bus.req_we = we;
    bus.req_wdata = $urandom;
  endtask

  task automatic pulse(int k, logic [31:0] d);
    bus.tgt_rsp_valid = 4'(1 << k);
    bus.tgt_rsp_rdata[k] = d;
    bus.tgt_rsp_err[k] = 1'b0;
  endtask

  task automatic respond(bit en);
    int e, k;
    bus.tgt_rsp_valid = '0;
    if (en && await_q.size() > 0 && $urandom % 3 == 0) begin
      e = await_q[0];
      k = e & 7;
      bus.tgt_rsp_valid = 4'(1 << k);
      bus.tgt_rsp_rdata[k] = (e & 16) != 0 ? 32'h0 : $urandom;
      bus.tgt_rsp_err[k] = ($urandom % 8) == 0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pt;
    logic [31:0] a;
    req(Base, 1'b0);
    bus.req_be = '1;
    bus.rsp_ready = 1'b0;
    bus.tgt_req_ready = 4'hf;
    bus.tgt_rsp_valid = '0;
    bus.tgt_rsp_rdata = '0;
    bus.tgt_rsp_err = '0;
    repeat (2) step();
    @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    step();
    rst_n = 1'b1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    step();
    // read of target 1 answered two cycles after acceptance
    req(32'h4000_1004, 1'b0);
    @(negedge clk);
    chk("t1_tgt_valid", 64'(bus.tgt_req_valid), 64'h2);
    chk("t1_ready", 64'(bus.req_ready), 64'h1);
    step();
    bus.req_valid = 1'b0;
    step();
    pulse(1, 32'hDEAD_BEEF);
    step();
    bus.tgt_rsp_valid = '0;
    @(negedge clk);
    chk("t1_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    chk("t1_rdata", 64'(bus.rsp_rdata), 64'hDEAD_BEEF);
    chk("t1_err", 64'(bus.rsp_err), 64'h0);
    step();
    @(negedge clk);
    chk("t1_drained", 64'(bus.rsp_valid), 64'h0);
    chk("t1_cnt", 64'(dut.cnt_q), 64'h0);
    step();
    // write outside the window produces a decode error
    req(32'h4000_4000, 1'b1);
    @(negedge clk);
    chk("t2_ready", 64'(bus.req_ready), 64'h1);
    chk("t2_no_tgt", 64'(bus.tgt_req_valid), 64'h0);
    step();
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("t2_err", 64'(bus.rsp_err), 64'h1);
    chk("t2_rdata", 64'(bus.rsp_rdata), 64'h0);
    step();
    // four reads to target 2 fill the window; the fifth waits for a pop
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req(32'h4000_2000 + 32'(4 * i), 1'b0);
      @(negedge clk);
      chk("t3_accept", 64'(bus.req_ready), 64'h1);
      step();
    end
    req(32'h4000_2010, 1'b0);
    for (int i = 0; i < 4; i++) begin
      pulse(2, 32'(100 + i));
      @(negedge clk);
      chk("t3_stall", 64'(bus.req_ready), 64'h0);
      step();
    end
    bus.tgt_rsp_valid = '0;
    @(negedge clk);
    chk("t3_stall_full", 64'(bus.req_ready), 64'h0);
    chk("t3_head", 64'(bus.rsp_rdata), 64'd100);
    step();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("t3_stall_pop", 64'(bus.req_ready), 64'h0);
    step();
    @(negedge clk);
    chk("t3_resume", 64'(bus.req_ready), 64'h1);
    step();
    bus.req_valid = 1'b0;
    pulse(2, 32'd104);
    step();
    bus.tgt_rsp_valid = '0;
    repeat (6) step();
    // accept and pop together at two outstanding
    bus.rsp_ready = 1'b0;
    repeat (2) begin
      req(32'h4000_2000, 1'b0);
      step();
    end
    bus.req_valid = 1'b0;
    pulse(2, 32'd200);
    step();
    pulse(2, 32'd201);
    step();
    bus.tgt_rsp_valid = '0;
    step();
    req(32'h4000_2008, 1'b0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("t5_ready", 64'(bus.req_ready), 64'h1);
    chk("t5_head", 64'(bus.rsp_rdata), 64'd200);
    step();
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("t5_cnt", 64'(dut.cnt_q), 64'h2);
    step();
    pulse(2, 32'd202);
    step();
    bus.tgt_rsp_valid = '0;
    repeat (5) step();
    // target switch waits for the earlier response to leave
    req(32'h4000_0000, 1'b0);
    @(negedge clk);
    chk("t4_accept", 64'(bus.req_ready), 64'h1);
    step();
    req(32'h4000_3000, 1'b0);
    @(negedge clk);
    chk("t4_hold", 64'(bus.req_ready), 64'h0);
    step();
    pulse(0, 32'h11);
    step();
    bus.tgt_rsp_valid = '0;
    @(negedge clk);
    chk("t4_first", 64'(bus.rsp_rdata), 64'h11);
    chk("t4_hold_rsp", 64'(bus.req_ready), 64'h0);
    step();
    @(negedge clk);
    chk("t4_switch", 64'(bus.tgt_req_valid), 64'h8);
    step();
    bus.req_valid = 1'b0;
    pulse(3, 32'h33);
    step();
    bus.tgt_rsp_valid = '0;
    @(negedge clk);
    chk("t4_second", 64'(bus.rsp_rdata), 64'h33);
    step();
    // reset with three outstanding drops everything, late response ignored
    bus.rsp_ready = 1'b0;
    repeat (3) begin
      req(32'h4000_1000, 1'b0);
      step();
    end
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("t6_cnt3", 64'(dut.cnt_q), 64'h3);
    step();
    rst_n = 1'b0;
    req(32'h4000_1000, 1'b0);
    @(negedge clk);
    chk("t6_rst_ready", 64'(bus.req_ready), 64'h0);
    step();
    rst_n = 1'b1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("t6_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("t6_rdata", 64'(bus.rsp_rdata), 64'h0);
    chk("t6_cnt", 64'(dut.cnt_q), 64'h0);
    step();
    pulse(1, 32'h77);
    step();
    bus.tgt_rsp_valid = '0;
    repeat (2) begin
      @(negedge clk);
      chk("t6_late", 64'(bus.rsp_valid), 64'h0);
      step();
    end
    // randomized traffic
    pt = 0;
    for (int c = 0; c < 3000; c++) begin
      int r;
      rst_n = ($urandom % 400) != 0;
      r = $urandom % 16;
      if (r < 12) begin
        pt = ($urandom % 2) != 0 ? pt : int'($urandom % 4);
        a = Base + 32'(pt << 12) + ($urandom & 32'hffc);
      end else if (r < 14) a = Base + 32'((4 + $urandom % 8) << 12) + ($urandom & 32'hffc);
      else if (r == 14) a = $urandom % Base;
      else a = 32'hFFFF_FFFC;
      req(a, $urandom % 2 == 0);
      bus.req_valid = ($urandom % 4) != 0;
      bus.req_be = 4'($urandom);
      bus.rsp_ready = ($urandom % 3) != 0;
      bus.tgt_req_ready = 4'($urandom);
      respond(1'b1);
      step();
    end
    rst_n = 1'b1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (80) begin
      respond(1'b1);
      step();
    end
    @(negedge clk);
    chk("end_cnt", 64'(dut.cnt_q), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
